// File: rtl/thermometer_poller.sv
// rtl/thermometer_poller.sv - periodic temperature sensor poller over a simple mem bus
//
// Every PERIOD_CYCLES while enabled, it writes 1 to BASE_ADDR+4 to start a
// conversion. It then waits SETTLE_CYCLES and reads the result byte from
// BASE_ADDR+8. It publishes the raw byte and a 4-sample running mean.
//
// Ports:
//   clk, resetn          clock, asynchronous active-low reset
//   enable               periodic polling enabled
//   clear_err            clears the sticky timeout flag
//   mem_valid/mem_ready  bus handshake (master side)
//   mem_addr/mem_wdata   bus address and write data
//   mem_wstrb            byte write strobes (0 for reads)
//   mem_rdata            bus read data (only [7:0] is used)
//   temp_raw             last sampled byte
//   temp_avg             mean of the last 4 samples
//   sample_stb           one-cycle pulse when a new sample lands
//   busy                 a bus transaction is in flight
//   err                  sticky: a bus access timed out

module thermometer_poller #(
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter int unsigned PERIOD_CYCLES  = 1000000,
  parameter int unsigned SETTLE_CYCLES  = 16384,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        enable,
  input  logic        clear_err,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  output logic [7:0]  temp_raw,
  output logic [7:0]  temp_avg,
  output logic        sample_stb,
  output logic        busy,
  output logic        err
);

  typedef enum logic [2:0] {IDLE, WRITE, SETTLE, READ, UPDATE} state_t;

  localparam logic [31:0] WR_ADDR      = BASE_ADDR + 32'd4;
  localparam logic [31:0] RD_ADDR      = BASE_ADDR + 32'd8;
  localparam logic [31:0] PERIOD_LAST  = 32'(PERIOD_CYCLES - 1);
  localparam logic [31:0] SETTLE_LAST  = 32'(SETTLE_CYCLES - 1);
  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

  state_t          state_q;
  logic [31:0]     per_cnt_q, per_cnt_d;
  logic            pending_q, pending_d;
  logic            per_tick;
  logic [31:0]     settle_cnt_q;
  logic [31:0]     tmo_cnt_q;
  logic            first_q;
  logic [3:0][7:0] hist_q;
  logic [9:0]      hist_sum;

  logic            mem_valid_q;
  logic [31:0]     mem_addr_q;
  logic [31:0]     mem_wdata_q;
  logic [3:0]      mem_wstrb_q;
  logic [7:0]      temp_raw_q;
  logic [7:0]      temp_avg_q;
  logic            sample_stb_q;
  logic            err_q;

  // Only the low byte of the read data carries the temperature.
  logic            unused_rdata;
  assign unused_rdata = ^mem_rdata[31:8];

  // ---------------------------------------------------------------------
  // Period counter and single-entry request flag
  // ---------------------------------------------------------------------
  assign per_tick = enable && (per_cnt_q == PERIOD_LAST);

  always_comb begin
    per_cnt_d = per_cnt_q;
    pending_d = pending_q;
    if (!enable) begin
      per_cnt_d = '0;
      pending_d = 1'b0;
    end else begin
      per_cnt_d = per_tick ? '0 : per_cnt_q + 32'd1;
      // A tick while already pending changes nothing, so the extra request
      // is dropped. A tick in the cycle IDLE consumes the flag re-arms it.
      if (per_tick) begin
        pending_d = 1'b1;
      end else if (state_q == IDLE) begin
        pending_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      per_cnt_q <= '0;
      pending_q <= 1'b0;
    end else begin
      per_cnt_q <= per_cnt_d;
      pending_q <= pending_d;
    end
  end

  // ---------------------------------------------------------------------
  // Transaction FSM with registered bus and sample outputs
  // ---------------------------------------------------------------------
  assign hist_sum = {2'b00, hist_q[0]} + {2'b00, hist_q[1]}
                  + {2'b00, hist_q[2]} + {2'b00, hist_q[3]};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      settle_cnt_q <= '0;
      tmo_cnt_q    <= '0;
      first_q      <= 1'b1;
      hist_q       <= '0;
      mem_valid_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_wstrb_q  <= '0;
      temp_raw_q   <= '0;
      temp_avg_q   <= '0;
      sample_stb_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      sample_stb_q <= 1'b0;
      // A timeout below assigns err_q later in this block, so set wins.
      if (clear_err) begin
        err_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (pending_q) begin
            state_q     <= WRITE;
            mem_valid_q <= 1'b1;
            mem_addr_q  <= WR_ADDR;
            mem_wdata_q <= 32'd1;
            mem_wstrb_q <= 4'b0001;
            tmo_cnt_q   <= '0;
          end
        end

        WRITE: begin
          // Ready is checked before the timeout, so a ready in the expiry
          // cycle still counts as a completed access.
          if (mem_ready) begin
            state_q      <= SETTLE;
            mem_valid_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_wstrb_q  <= '0;
            settle_cnt_q <= '0;
          end else if (tmo_cnt_q == TIMEOUT_LAST) begin
            state_q     <= IDLE;
            mem_valid_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
            err_q       <= 1'b1;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 32'd1;
          end
        end

        SETTLE: begin
          if (settle_cnt_q == SETTLE_LAST) begin
            state_q     <= READ;
            mem_valid_q <= 1'b1;
            mem_addr_q  <= RD_ADDR;
            tmo_cnt_q   <= '0;
          end else begin
            settle_cnt_q <= settle_cnt_q + 32'd1;
          end
        end

        READ: begin
          if (mem_ready) begin
            // The sample is published on entry to UPDATE, so temp_raw and
            // sample_stb are both visible during the UPDATE cycle.
            state_q      <= UPDATE;
            mem_valid_q  <= 1'b0;
            mem_addr_q   <= '0;
            temp_raw_q   <= mem_rdata[7:0];
            sample_stb_q <= 1'b1;
            first_q      <= 1'b0;
            if (first_q) begin
              hist_q <= {4{mem_rdata[7:0]}};
            end else begin
              hist_q <= {hist_q[2:0], mem_rdata[7:0]};
            end
          end else if (tmo_cnt_q == TIMEOUT_LAST) begin
            state_q     <= IDLE;
            mem_valid_q <= 1'b0;
            mem_addr_q  <= '0;
            err_q       <= 1'b1;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 32'd1;
          end
        end

        UPDATE: begin
          state_q    <= IDLE;
          temp_avg_q <= hist_sum[9:2];
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign mem_valid  = mem_valid_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_wstrb  = mem_wstrb_q;
  assign temp_raw   = temp_raw_q;
  assign temp_avg   = temp_avg_q;
  assign sample_stb = sample_stb_q;
  assign busy       = (state_q != IDLE);
  assign err        = err_q;

endmodule

// File: tb/tb_thermometer_poller.sv
// tb/tb_thermometer_poller.sv - directed self-checking bench for thermometer_poller

module tb_thermometer_poller;

  localparam logic [31:0] BASE    = 32'h4000_0000;
  localparam int          PERIOD  = 100;
  localparam int          SETTLE  = 10;
  localparam int          TIMEOUT = 255;

  logic        clk;
  logic        resetn;
  logic        enable;
  logic        clear_err;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic [7:0]  temp_raw;
  logic [7:0]  temp_avg;
  logic        sample_stb;
  logic        busy;
  logic        err;

  int checks = 0;
  int errors = 0;

  thermometer_poller #(
    .BASE_ADDR      (BASE),
    .PERIOD_CYCLES  (PERIOD),
    .SETTLE_CYCLES  (SETTLE),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .enable     (enable),
    .clear_err  (clear_err),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wstrb  (mem_wstrb),
    .mem_rdata  (mem_rdata),
    .temp_raw   (temp_raw),
    .temp_avg   (temp_avg),
    .sample_stb (sample_stb),
    .busy       (busy),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    resetn    = 1'b0;
    enable    = 1'b0;
    clear_err = 1'b0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_valid(input int max_cyc, output bit got, output int n);
    n = 0;
    while (mem_valid !== 1'b1 && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    got = (mem_valid === 1'b1);
  endtask

  // Runs one full poll: ready two cycles after each valid, returns observations.
  task automatic do_poll(input logic [7:0] data, output bit ok,
                         output logic [31:0] wa, output logic [31:0] wd, output logic [3:0] ws,
                         output int gap, output logic [31:0] ra, output logic [31:0] rd_wd,
                         output logic [3:0] rs, output logic [7:0] raw, output logic [7:0] avg,
                         output int stbs);
    bit got;
    int n;
    ok = 1'b1; wa = '0; wd = '0; ws = '0; gap = 0; ra = '0; rd_wd = '1; rs = '1;
    raw = '0; avg = '0; stbs = 0;
    wait_valid(200, got, n);
    if (!got) begin ok = 1'b0; return; end
    wa = mem_addr; wd = mem_wdata; ws = mem_wstrb;
    @(negedge clk); @(negedge clk);
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    gap = 1;
    while (mem_valid !== 1'b1 && gap < 50) begin
      @(negedge clk);
      gap++;
    end
    if (mem_valid !== 1'b1) begin ok = 1'b0; return; end
    ra = mem_addr; rd_wd = mem_wdata; rs = mem_wstrb;
    @(negedge clk); @(negedge clk);
    mem_ready = 1'b1;
    mem_rdata = {24'hABCDEF, data};
    @(negedge clk);
    mem_ready = 1'b0;
    raw = temp_raw;
    stbs += int'(sample_stb);
    @(negedge clk);
    avg = temp_avg;
    repeat (4) begin
      stbs += int'(sample_stb);
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0; enable = 1'b0; clear_err = 1'b0; mem_ready = 1'b0; mem_rdata = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({mem_valid, busy, err, sample_stb} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags: got %b expected 0000", {mem_valid, busy, err, sample_stb});
    end
    checks++;
    if ({mem_addr, mem_wdata, mem_wstrb} !== 68'h0) begin
      errors++; $display("FAIL reset_bus: got %h expected 0", {mem_addr, mem_wdata, mem_wstrb});
    end
    checks++;
    if ({temp_raw, temp_avg} !== 16'h0) begin
      errors++; $display("FAIL reset_temps: got %h expected 0000", {temp_raw, temp_avg});
    end
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_poll();
    bit ok, got; int gap, stbs, n;
    logic [31:0] wa, wd, ra, rwd; logic [3:0] ws, rs; logic [7:0] raw, avg;
    do_reset();
    enable = 1'b1;
    wait_valid(200, got, n);
    checks++;
    if (!got || n < PERIOD || n > PERIOD + 2) begin
      errors++; $display("FAIL first_poll_delay: got %0d cycles expected %0d..%0d", n, PERIOD, PERIOD + 2);
    end
    do_poll(8'h2A, ok, wa, wd, ws, gap, ra, rwd, rs, raw, avg, stbs);
    checks++;
    if (ok !== 1'b1) begin errors++; $display("FAIL single_done: got %b expected 1", ok); end
    checks++;
    if (wa !== BASE + 32'd4) begin errors++; $display("FAIL write_addr: got %h expected %h", wa, BASE + 32'd4); end
    checks++;
    if (wd !== 32'd1) begin errors++; $display("FAIL write_data: got %h expected 00000001", wd); end
    checks++;
    if (ws !== 4'b0001) begin errors++; $display("FAIL write_strb: got %b expected 0001", ws); end
    checks++;
    if (gap !== SETTLE + 1) begin errors++; $display("FAIL settle_gap: got %0d expected %0d", gap, SETTLE + 1); end
    checks++;
    if (ra !== BASE + 32'd8) begin errors++; $display("FAIL read_addr: got %h expected %h", ra, BASE + 32'd8); end
    checks++;
    if ({rwd, rs} !== 36'h0) begin errors++; $display("FAIL read_wdata_wstrb: got %h expected 0", {rwd, rs}); end
    checks++;
    if (raw !== 8'h2A) begin errors++; $display("FAIL single_raw: got %h expected 2a", raw); end
    checks++;
    if (avg !== 8'h2A) begin errors++; $display("FAIL single_avg: got %h expected 2a", avg); end
    checks++;
    if (stbs !== 1) begin errors++; $display("FAIL single_stb_count: got %0d expected 1", stbs); end
  endtask

  task automatic test_average();
    logic [7:0] samp [4];
    logic [7:0] expv [4];
    bit ok; int gap, stbs;
    logic [31:0] wa, wd, ra, rwd; logic [3:0] ws, rs; logic [7:0] raw, avg;
    samp = '{8'h10, 8'h14, 8'h18, 8'h1C};
    expv = '{8'h10, 8'h11, 8'h13, 8'h16};
    do_reset();
    enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      do_poll(samp[i], ok, wa, wd, ws, gap, ra, rwd, rs, raw, avg, stbs);
      checks++;
      if (ok !== 1'b1 || raw !== samp[i]) begin
        errors++; $display("FAIL avg_raw[%0d]: got %h ok=%b expected %h", i, raw, ok, samp[i]);
      end
      checks++;
      if (avg !== expv[i]) begin
        errors++; $display("FAIL avg_value[%0d]: got %h expected %h", i, avg, expv[i]);
      end
    end
  endtask

  task automatic test_timeout();
    bit got; int n; bit stb_seen;
    do_reset();
    enable = 1'b1;
    wait_valid(200, got, n);
    @(negedge clk); @(negedge clk);
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    wait_valid(50, got, n);
    checks++;
    if (!got || mem_addr !== BASE + 32'd8) begin
      errors++; $display("FAIL timeout_read_start: got valid=%b addr=%h expected 1 %h", got, mem_addr, BASE + 32'd8);
    end
    enable = 1'b0;
    n = 0; stb_seen = 1'b0;
    while (mem_valid === 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
      stb_seen |= sample_stb;
    end
    checks++;
    if (n !== TIMEOUT) begin errors++; $display("FAIL timeout_len: got %0d expected %0d", n, TIMEOUT); end
    repeat (3) begin
      stb_seen |= sample_stb;
      @(negedge clk);
    end
    checks++;
    if ({err, busy, stb_seen} !== 3'b100) begin
      errors++; $display("FAIL timeout_flags err/busy/stb: got %b expected 100", {err, busy, stb_seen});
    end
    checks++;
    if ({temp_raw, temp_avg} !== 16'h0) begin
      errors++; $display("FAIL timeout_temps: got %h expected 0000", {temp_raw, temp_avg});
    end
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL clear_err: got %b expected 0", err); end
  endtask

  task automatic test_enable_drop();
    bit got, act; int n, stbs;
    do_reset();
    enable = 1'b1;
    wait_valid(200, got, n);
    @(negedge clk); @(negedge clk);
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    repeat (3) @(negedge clk);
    enable = 1'b0;
    wait_valid(50, got, n);
    checks++;
    if (!got) begin errors++; $display("FAIL drop_read_start: got valid=%b expected 1", got); end
    @(negedge clk);
    mem_ready = 1'b1;
    mem_rdata = 32'h0000_0055;
    @(negedge clk);
    mem_ready = 1'b0;
    stbs = 0;
    repeat (4) begin
      stbs += int'(sample_stb);
      @(negedge clk);
    end
    checks++;
    if (stbs !== 1 || temp_raw !== 8'h55) begin
      errors++; $display("FAIL drop_sample: got stb=%0d raw=%h expected 1 55", stbs, temp_raw);
    end
    act = 1'b0;
    repeat (300) begin
      act |= mem_valid | busy;
      @(negedge clk);
    end
    checks++;
    if (act !== 1'b0) begin errors++; $display("FAIL drop_quiet: got activity=%b expected 0", act); end
  endtask

  task automatic test_reset_mid();
    bit got; int n;
    do_reset();
    enable = 1'b1;
    wait_valid(200, got, n);
    checks++;
    if (!got || mem_addr !== BASE + 32'd4) begin
      errors++; $display("FAIL mid_write_start: got valid=%b addr=%h expected 1 %h", got, mem_addr, BASE + 32'd4);
    end
    resetn = 1'b0;
    #1;
    checks++;
    if ({mem_valid, busy, err, sample_stb} !== 4'b0000) begin
      errors++; $display("FAIL mid_reset_flags: got %b expected 0000", {mem_valid, busy, err, sample_stb});
    end
    checks++;
    if ({mem_addr, mem_wdata, mem_wstrb, temp_raw, temp_avg} !== 84'h0) begin
      errors++; $display("FAIL mid_reset_outputs: got %h expected 0", {mem_addr, mem_wdata, mem_wstrb, temp_raw, temp_avg});
    end
    @(negedge clk);
    resetn = 1'b1;
    wait_valid(200, got, n);
    checks++;
    if (!got || n < PERIOD || n > PERIOD + 2) begin
      errors++; $display("FAIL mid_reset_next_poll: got %0d cycles expected %0d..%0d", n, PERIOD, PERIOD + 2);
    end
  endtask

  task automatic test_idle_ready();
    bit act, ok; int gap, stbs;
    logic [31:0] wa, wd, ra, rwd; logic [3:0] ws, rs; logic [7:0] raw, avg;
    do_reset();
    enable = 1'b1;
    mem_ready = 1'b1;
    mem_rdata = 32'hFFFF_FFFF;
    act = 1'b0;
    repeat (20) begin
      @(negedge clk);
      act |= mem_valid | busy | sample_stb;
    end
    mem_ready = 1'b0;
    checks++;
    if (act !== 1'b0 || temp_raw !== 8'h00) begin
      errors++; $display("FAIL idle_ready_ignored: got activity=%b raw=%h expected 0 00", act, temp_raw);
    end
    do_poll(8'h33, ok, wa, wd, ws, gap, ra, rwd, rs, raw, avg, stbs);
    checks++;
    if (ok !== 1'b1 || raw !== 8'h33 || avg !== 8'h33) begin
      errors++; $display("FAIL idle_then_poll: got ok=%b raw=%h avg=%h expected 1 33 33", ok, raw, avg);
    end
  endtask

  initial begin
    resetn = 1'b0; enable = 1'b0; clear_err = 1'b0; mem_ready = 1'b0; mem_rdata = '0;
    test_reset();
    test_single_poll();
    test_average();
    test_timeout();
    test_enable_drop();
    test_reset_mid();
    test_idle_ready();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/thermometer_poller.md
THERMOMETER_POLLER -- requirements
Module: thermometer_poller

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_0000, base address of the temperature register block on the mem bus.
REQ-002 SHALL have parameter PERIOD_CYCLES, default 1000000, cycles between poll requests.
REQ-003 SHALL have parameter SETTLE_CYCLES, default 16384, wait between start write and result read.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 255, maximum wait for mem_ready per bus access.
REQ-005 SHALL have port clk, input, 1, single clock; all logic on posedge.
REQ-006 SHALL have port resetn, input, 1, reset that is asynchronous and active-low.
REQ-007 SHALL have port enable, input, 1, periodic polling enabled.
REQ-008 SHALL have port clear_err, input, 1, clears sticky err.
REQ-009 SHALL have bus master ports mem_valid (out, 1), mem_ready (in, 1), mem_addr (out, 32), mem_wdata (out, 32), mem_wstrb (out, 4) and mem_rdata (in, 32).
REQ-010 SHALL have port temp_raw, output, 8, last sampled byte.
REQ-011 SHALL have port temp_avg, output, 8, mean of last 4 samples.
REQ-012 SHALL have port sample_stb, output, 1, one-cycle pulse on a new sample.
REQ-013 SHALL have ports busy (output, 1, FSM not IDLE) and err (output, 1, sticky timeout flag).

Function
REQ-014 SHALL implement FSM states IDLE, WRITE, SETTLE, READ and UPDATE.
REQ-015 Period counter SHALL count while enable=1, wrap 0..PERIOD_CYCLES-1, and set a pending flag at PERIOD_CYCLES-1.
REQ-016 Pending SHALL hold at most one request; requests arriving while pending is already set SHALL be dropped.
REQ-017 enable=0 SHALL hold the counter at 0 and clear pending; an in-flight transaction SHALL still complete.
REQ-018 IDLE->WRITE SHALL occur when pending=1, and SHALL clear pending in the same cycle.
REQ-019 WRITE SHALL drive mem_valid=1, mem_addr=BASE_ADDR+4, mem_wdata=1 and mem_wstrb=4'b0001, holding all stable until mem_ready=1 is sampled.
REQ-020 On mem_ready in WRITE, mem_valid SHALL deassert the next cycle and the FSM SHALL go to SETTLE.
REQ-021 SETTLE SHALL last exactly SETTLE_CYCLES cycles, then go to READ.
REQ-022 READ SHALL drive mem_valid=1, mem_addr=BASE_ADDR+8 and mem_wstrb=0; on mem_ready it SHALL capture mem_rdata[7:0] and go to UPDATE.
REQ-023 mem_valid SHALL be 0 in IDLE, SETTLE and UPDATE; mem_wdata and mem_wstrb SHALL be 0 outside WRITE.
REQ-024 UPDATE (one cycle) SHALL set temp_raw to the captured byte, shift it into a 4-entry history and assert sample_stb, then go to IDLE.
REQ-025 temp_avg SHALL equal the 10-bit sum of the 4 history entries >> 2 (truncating), valid the cycle after sample_stb.
REQ-026 The first sample after reset SHALL fill all 4 history entries, so that temp_avg equals temp_raw.
REQ-027 A per-access timeout counter SHALL start at mem_valid assertion; if it reaches TIMEOUT_CYCLES without mem_ready, the poller SHALL drop mem_valid, set err, go to IDLE, and leave temp_raw and temp_avg unchanged.
REQ-028 mem_ready received in the same cycle the timeout expires SHALL be treated as success.
REQ-029 clear_err=1 SHALL clear err unless a timeout sets it in the same cycle, in which case set wins.
REQ-030 mem_ready SHALL be ignored whenever mem_valid=0.

Reset
REQ-031 resetn=0 SHALL asynchronously force IDLE with mem_valid=0 and mem_addr, mem_wdata, mem_wstrb, temp_raw, temp_avg, sample_stb, busy and err all 0.
REQ-032 resetn=0 SHALL asynchronously clear the period counter, pending flag, settle/timeout counters and history, including mid-transaction.
REQ-033 After reset release, the first sample SHALL follow REQ-026.

Verification
REQ-034 Bench SHALL cover: PERIOD=100, SETTLE=10, ready after 2 cycles, rdata=8'h2A -> write at +4 with wdata=1 and wstrb=1, read at +8 11+ cycles after the write ack, temp_raw=temp_avg=8'h2A, one sample_stb.
REQ-035 Bench SHALL cover: samples 8'h10, 8'h14, 8'h18, 8'h1C -> temp_avg sequence 10, 11, 13, 16 (hex).
REQ-036 Bench SHALL cover: mem_ready never asserted in READ -> mem_valid drops after 255 cycles, err=1, no sample_stb; clear_err -> err=0.
REQ-037 Bench SHALL cover: enable dropped during SETTLE -> read still completes with one sample_stb, then no further bus activity.
REQ-038 Bench SHALL cover: resetn low during WRITE with mem_valid=1 -> mem_valid=0 immediately, all outputs 0; next poll starts PERIOD_CYCLES after enable.
REQ-039 Bench SHALL cover: mem_ready pulsed while in IDLE -> no state change.
